// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches, holds the fetched instruction for
// decode, and restarts fetch on redirect without aborting an in-flight request.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic [31:0] pc_inc;
    logic [31:0] drain_next;

    assign target     = {redirect_pc[31:2], 2'b00};
    assign pc_inc     = pc_q + 32'd4;
    assign drain_next = redirect ? target : pc_q;

    // An ack only counts while a request is actually outstanding (req_q), so a
    // stray ack in the first cycle after reset is ignored.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = req_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    if (req_q && !imem_ack) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = target;
                        req_d  = 1'b1;
                    end
                end else if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    addr_d  = target;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                pc_d = drain_next;
                // Old address stays on the bus until the abandoned fetch completes.
                if (imem_ack) begin
                    addr_d  = drain_next;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= NOP;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; inputs are driven and outputs
// sampled on the falling clock edge.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks;
    int failures;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .opcode(opcode),
        .instr_valid(instr_valid),
        .pc_out(pc_out),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, instr, pc_out} !== {1'b0, 1'b0, 32'h0000_0013, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_state: req=%b valid=%b instr=%h pc_out=%h expected 0 0 00000013 00000000",
                     imem_req, instr_valid, instr, pc_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_req: req=%b expected 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL first_req: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0033;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, pc_out, opcode, imem_req} !== {1'b1, 32'h0, 7'b0110011, 1'b0}) begin
            failures++;
            $display("[TB] FAIL zero_wait_valid: valid=%b pc_out=%h opcode=%b req=%b expected 1 00000000 0110011 0",
                     instr_valid, pc_out, opcode, imem_req);
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
            failures++;
            $display("[TB] FAIL zero_wait_next: req=%b addr=%h valid=%b expected 1 00000004 0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
                failures++;
                $display("[TB] FAIL wait_addr_hold[%0d]: req=%b addr=%h valid=%b expected 1 00000004 0",
                         i, imem_req, imem_addr, instr_valid);
            end
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 32'h4, 32'h0050_0093}) begin
            failures++;
            $display("[TB] FAIL wait_valid: valid=%b pc_out=%h instr=%h expected 1 00000004 00500093",
                     instr_valid, pc_out, instr);
        end
        @(negedge clk);
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
            failures++;
            $display("[TB] FAIL wait_single_pulse: valid=%b req=%b addr=%h expected 0 1 00000008",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5677;
        @(negedge clk);
        imem_ack = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, imem_req, instr, pc_out} !== {1'b1, 1'b0, 32'h1234_5677, 32'h8}) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d]: valid=%b req=%b instr=%h pc_out=%h expected 1 0 12345677 00000008",
                         i, instr_valid, imem_req, instr, pc_out);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'hC, 1'b0}) begin
            failures++;
            $display("[TB] FAIL stall_release: req=%b addr=%h valid=%b expected 1 0000000c 0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_hold();
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_006F;
        @(negedge clk);
        imem_ack = 1'b0;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            failures++;
            $display("[TB] FAIL redirect_hold: valid=%b req=%b addr=%h expected 0 1 00000100",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_drain();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
            failures++;
            $display("[TB] FAIL drain_hold_1: req=%b addr=%h valid=%b expected 1 00000100 0",
                     imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
            failures++;
            $display("[TB] FAIL drain_hold_2: req=%b addr=%h valid=%b expected 1 00000100 0",
                     imem_req, imem_addr, instr_valid);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            failures++;
            $display("[TB] FAIL drain_discard: valid=%b req=%b addr=%h expected 0 1 00000200",
                     instr_valid, imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0113;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, pc_out, instr} !== {1'b1, 32'h200, 32'h0000_0113}) begin
            failures++;
            $display("[TB] FAIL drain_new_target: valid=%b pc_out=%h instr=%h expected 1 00000200 00000113",
                     instr_valid, pc_out, instr);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        redirect = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
            failures++;
            $display("[TB] FAIL redirect_ack_discard: valid=%b req=%b addr=%h expected 0 1 fffffffc",
                     instr_valid, imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0213;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, pc_out} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++;
            $display("[TB] FAIL wrap_valid: valid=%b pc_out=%h expected 1 fffffffc", instr_valid, pc_out);
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL wrap_addr: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_midwait();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, instr, pc_out, imem_addr} !== {1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL async_reset: req=%b valid=%b instr=%h pc_out=%h addr=%h expected 0 0 00000013 00000000 00000000",
                     imem_req, instr_valid, instr, pc_out, imem_addr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if ({instr_valid, imem_req, instr} !== {1'b0, 1'b1, 32'h0000_0013}) begin
            failures++;
            $display("[TB] FAIL late_ack_ignored: valid=%b req=%b instr=%h expected 0 1 00000013",
                     instr_valid, imem_req, instr);
        end
    endtask

    task automatic test_back_to_back();
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = 32'h0000_1000 + 32'(k);
            @(negedge clk);
            checks++;
            if ({instr_valid, pc_out, instr} !== {1'b1, 32'(4 * k), 32'h0000_1000 + 32'(k)}) begin
                failures++;
                $display("[TB] FAIL b2b_valid[%0d]: valid=%b pc_out=%h instr=%h expected 1 %h %h",
                         k, instr_valid, pc_out, instr, 32'(4 * k), 32'h0000_1000 + 32'(k));
            end
            @(negedge clk);
            checks++;
            if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'(4 * (k + 1))}) begin
                failures++;
                $display("[TB] FAIL b2b_fetch[%0d]: valid=%b req=%b addr=%h expected 0 1 %h",
                         k, instr_valid, imem_req, imem_addr, 32'(4 * (k + 1)));
            end
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_hold();
        test_redirect_drain();
        test_wrap();
        test_reset_midwait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port imem_ack  input  1  memory has returned data on imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  registered instruction presented to decode.
REQ-009 SHALL have port opcode  output  7  instr[6:0]; feeds control_unit instr input.
REQ-010 SHALL have port instr_valid  output  1  instr/pc_out hold a live instruction.
REQ-011 SHALL have port pc_out  output  32  address of the instruction on instr.
REQ-012 SHALL have port stall  input  1  downstream not ready; instruction not consumed this cycle.
REQ-013 SHALL have port redirect  input  1  taken Branch/Jump; fetch restarts at redirect_pc.
REQ-014 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 00.

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, DRAIN; registered pc holds the next fetch address.
REQ-016 FETCH: SHALL drive imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-017 FETCH with imem_ack=1 and redirect=0: SHALL register instr<=imem_rdata, pc_out<=pc, instr_valid<=1, go HOLD.
REQ-018 Zero-wait memory (ack in same cycle as req) SHALL be supported; instr_valid rises the following cycle.
REQ-019 HOLD: imem_req=0; instr, opcode, pc_out SHALL remain stable while stall=1.
REQ-020 HOLD with stall=0 and redirect=0: instruction consumed; pc<=pc+4, instr_valid<=0, go FETCH.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no error flag.
REQ-022 redirect SHALL take priority over stall and over a coinciding imem_ack.
REQ-023 redirect in HOLD, or in FETCH with imem_ack=1: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, rdata discarded, go FETCH.
REQ-024 redirect in FETCH with imem_ack=0: outstanding request SHALL NOT be aborted; pc<=redirect target, instr_valid<=0, go DRAIN.
REQ-025 DRAIN: imem_req=1 with the old address held; on imem_ack data SHALL be discarded, go FETCH at the new pc.
REQ-026 redirect in DRAIN SHALL overwrite the pending target; last redirect wins; state stays DRAIN.
REQ-027 redirect while instr_valid=0 and stall=1 SHALL behave per REQ-023/024; stall has no effect outside HOLD.
REQ-028 Steady-state throughput with zero-wait memory and stall=0 SHALL be one instruction per 2 cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force state=FETCH, pc=RESET_PC, imem_req=0, instr=32'h0000_0013 (NOP), instr_valid=0, pc_out=RESET_PC.
REQ-030 imem_req SHALL be 0 while rst_n=0; first request in the first clock after rst_n deasserts.
REQ-031 Reset mid-transaction (FETCH/DRAIN) SHALL abandon the request; a late imem_ack after reset SHALL be ignored unless imem_req=1.

Verification
REQ-032 Reset, zero-wait memory returning 32'h0000_0033 at 0x0, stall=0 -> instr_valid=1 at cycle 2 with pc_out=0, opcode=7'b0110011; next fetch at 0x4.
REQ-033 Memory ack after 3 wait cycles -> imem_addr constant for 4 cycles, single instr_valid pulse, pc_out matches address.
REQ-034 stall=1 for 5 cycles in HOLD -> instr, pc_out unchanged, imem_req=0 throughout; fetch of pc+4 after stall drops.
REQ-035 redirect=1, redirect_pc=32'h0000_0103 in HOLD with stall=1 -> instr_valid=0 next cycle, next imem_addr=32'h0000_0100.
REQ-036 redirect in FETCH with ack pending 2 cycles -> old address held to ack, data discarded, next req to new target, no instr_valid pulse for old data.
REQ-037 pc=32'hFFFF_FFFC consumed -> next imem_addr=32'h0000_0000; rst_n pulsed mid-wait -> outputs per REQ-029 asynchronously.
